// File: rtl/dcache_direct_wb.sv
// Direct-mapped, write-back, write-allocate L1 data cache.
// Hits finish in the MEM cycle; misses stall while the FSM writes back a dirty victim and then refills the line.
module dcache_direct_wb #(
    parameter int LINES     = 16,
    parameter int LINE_BITS = 256
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cpu_req_i,
    input  logic                 cpu_we_i,
    input  logic [31:0]          cpu_addr_i,
    input  logic [31:0]          cpu_data_i,
    output logic [31:0]          cpu_data_o,
    output logic                 cpu_stall_o,
    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic [31:0]          mem_addr_o,
    output logic [LINE_BITS-1:0] mem_data_o,
    input  logic [LINE_BITS-1:0] mem_data_i,
    input  logic                 mem_ack_i,
    output logic [1:0]           dbg_state_o
);
    localparam int OFF_W  = $clog2(LINE_BITS / 8);
    localparam int IDX_W  = $clog2(LINES);
    localparam int TAG_W  = 32 - OFF_W - IDX_W;
    localparam int WSEL_W = OFF_W - 2;
    localparam int BIT_W  = WSEL_W + 5;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [LINES-1:0]     valid_q, valid_d;
    logic [LINES-1:0]     dirty_q, dirty_d;
    logic [TAG_W-1:0]     tag_q  [LINES];
    logic [TAG_W-1:0]     tag_d  [LINES];
    logic [LINE_BITS-1:0] data_q [LINES];
    logic [LINE_BITS-1:0] data_d [LINES];

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  addr_tag;
    logic [WSEL_W-1:0] word_sel;
    logic [BIT_W-1:0]  word_bit;
    logic              hit;

    assign idx      = cpu_addr_i[OFF_W +: IDX_W];
    assign addr_tag = cpu_addr_i[31 -: TAG_W];
    assign word_sel = cpu_addr_i[2 +: WSEL_W];
    assign word_bit = {word_sel, 5'b0};
    assign hit      = valid_q[idx] && (tag_q[idx] == addr_tag);

    // Load data is only meaningful when the access is not stalled.
    assign cpu_data_o  = data_q[idx][word_bit +: 32];
    assign dbg_state_o = state_q;

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        dirty_d     = dirty_q;
        tag_d       = tag_q;
        data_d      = data_q;
        cpu_stall_o = 1'b0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_data_o  = '0;
        case (state_q)
            IDLE: begin
                if (cpu_req_i) begin
                    if (hit) begin
                        if (cpu_we_i) begin
                            data_d[idx][word_bit +: 32] = cpu_data_i;
                            dirty_d[idx]                = 1'b1;
                        end
                    end else begin
                        cpu_stall_o = 1'b1;
                        state_d     = (valid_q[idx] && dirty_q[idx]) ? WRITEBACK : ALLOCATE;
                    end
                end
            end
            WRITEBACK: begin
                cpu_stall_o = 1'b1;
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = {tag_q[idx], idx, {OFF_W{1'b0}}};
                mem_data_o  = data_q[idx];
                if (mem_ack_i) begin
                    dirty_d[idx] = 1'b0;
                    state_d      = ALLOCATE;
                end
            end
            ALLOCATE: begin
                cpu_stall_o = 1'b1;
                mem_req_o   = 1'b1;
                mem_addr_o  = {cpu_addr_i[31:OFF_W], {OFF_W{1'b0}}};
                if (mem_ack_i) begin
                    data_d[idx]  = mem_data_i;
                    tag_d[idx]   = addr_tag;
                    valid_d[idx] = 1'b1;
                    dirty_d[idx] = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Tag and data storage carry no reset; valid gates their use.
    always_ff @(posedge clk_i) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

endmodule
